// File: rtl/dlx_hex_pkg.sv
// dlx_hex_pkg: shared constants and scan-state encoding for the hex display path
package dlx_hex_pkg;
   localparam int NUM_DIGITS = 8;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_e;
endpackage

// File: rtl/hex_seg_decoder.sv
// hex_seg_decoder: 4-bit nibble to active-low gfedcba segment pattern
module hex_seg_decoder (
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);
   always_comb begin
      case (nib_i)
         4'h0: seg_o = 7'b1000000;
         4'h1: seg_o = 7'b1111001;
         4'h2: seg_o = 7'b0100100;
         4'h3: seg_o = 7'b0110000;
         4'h4: seg_o = 7'b0011001;
         4'h5: seg_o = 7'b0010010;
         4'h6: seg_o = 7'b0000010;
         4'h7: seg_o = 7'b1111000;
         4'h8: seg_o = 7'b0000000;
         4'h9: seg_o = 7'b0011000;
         4'hA: seg_o = 7'b0001000;
         4'hB: seg_o = 7'b0000011;
         4'hC: seg_o = 7'b1000110;
         4'hD: seg_o = 7'b0100001;
         4'hE: seg_o = 7'b0000110;
         default: seg_o = 7'b0001110;
      endcase
   end
endmodule

// File: rtl/gpio_hex_display.sv
// gpio_hex_display: scans a GPIO word through one shared decoder into shadow digits,
// then commits all eight digits in a single clock so no mixed old/new value is shown.
module gpio_hex_display
   import dlx_hex_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OVR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    gpio_o,
   input  logic                     we_gpio,
   input  logic                     blank_lz,
   output logic [6:0]               hex0,
   output logic [6:0]               hex1,
   output logic [6:0]               hex2,
   output logic [6:0]               hex3,
   output logic [6:0]               hex4,
   output logic [6:0]               hex5,
   output logic [6:0]               hex6,
   output logic [6:0]               hex7,
   output logic                     busy,
   output logic                     upd_done,
   output logic [OVR_CNT_WIDTH-1:0] ovr_cnt
);
   state_e                     state_q, state_d;
   logic [2:0]                 idx_q, idx_d;
   logic                       nz_q, nz_d, lz_q, lz_d, pend_lz_q, pend_lz_d;
   logic                       pend_v_q, pend_v_d, upd_q, upd_d;
   logic [DATA_WIDTH-1:0]      data_q, data_d, pend_q, pend_d, ld_data;
   logic [NUM_DIGITS-1:0][6:0] shadow_q, shadow_d, hex_q, hex_d;
   logic [OVR_CNT_WIDTH-1:0]   ovr_q, ovr_d;
   logic [3:0]                 nib;
   logic [6:0]                 seg;
   logic                       ld, ld_lz, ovr_inc;

   assign nib = data_q[{idx_q, 2'b00} +: 4];

   hex_seg_decoder u_dec (.nib_i(nib), .seg_o(seg));

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      nz_d     = nz_q;
      lz_d     = lz_q;
      data_d   = data_q;
      pend_d   = pend_q;
      pend_lz_d = pend_lz_q;
      pend_v_d = pend_v_q;
      shadow_d = shadow_q;
      hex_d    = hex_q;
      upd_d    = 1'b0;
      ld       = 1'b0;
      ld_data  = gpio_o;
      ld_lz    = blank_lz;
      ovr_inc  = 1'b0;
      case (state_q)
         IDLE: ld = we_gpio;
         SCAN: begin
            // leading zeros stay blank until the first nonzero nibble; digit 0 always shows
            shadow_d[idx_q] = (lz_q && !nz_q && nib == 4'h0 && idx_q != 3'd0) ? SEG_BLANK : seg;
            nz_d  = nz_q | (nib != 4'h0);
            idx_d = idx_q - 3'd1;
            state_d = (idx_q == 3'd0) ? COMMIT : SCAN;
            if (we_gpio) begin
               pend_d    = gpio_o;
               pend_lz_d = blank_lz;
               pend_v_d  = 1'b1;
               ovr_inc   = pend_v_q;
            end
         end
         COMMIT: begin
            hex_d = shadow_q;
            upd_d = 1'b1;
            pend_v_d = 1'b0;
            // a fresh write beats the held one; the held one is counted as lost
            ld       = we_gpio | pend_v_q;
            ld_data  = we_gpio ? gpio_o : pend_q;
            ld_lz    = we_gpio ? blank_lz : pend_lz_q;
            ovr_inc  = we_gpio & pend_v_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (ld) begin
         data_d  = ld_data;
         lz_d    = ld_lz;
         idx_d   = 3'd7;
         nz_d    = 1'b0;
         state_d = SCAN;
      end
      ovr_d = (ovr_inc && !(&ovr_q)) ? ovr_q + 1'b1 : ovr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= 3'd0;
         nz_q      <= 1'b0;
         lz_q      <= 1'b0;
         data_q    <= '0;
         pend_q    <= '0;
         pend_lz_q <= 1'b0;
         pend_v_q  <= 1'b0;
         shadow_q  <= {NUM_DIGITS{SEG_ZERO}};
         hex_q     <= {NUM_DIGITS{SEG_ZERO}};
         upd_q     <= 1'b0;
         ovr_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         nz_q      <= nz_d;
         lz_q      <= lz_d;
         data_q    <= data_d;
         pend_q    <= pend_d;
         pend_lz_q <= pend_lz_d;
         pend_v_q  <= pend_v_d;
         shadow_q  <= shadow_d;
         hex_q     <= hex_d;
         upd_q     <= upd_d;
         ovr_q     <= ovr_d;
      end
   end

   assign {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0} = hex_q;
   assign busy     = (state_q != IDLE) || pend_v_q;
   assign upd_done = upd_q;
   assign ovr_cnt  = ovr_q;
endmodule

// File: tb/tb_gpio_hex_display.sv
// tb_gpio_hex_display: randomized and directed stimulus, scoreboarded against a
// cycle-level model of write acceptance and a digit-rule model of the display.
module tb_gpio_hex_display;
   logic        clk, rst, we_gpio, blank_lz, busy, upd_done;
   logic [31:0] gpio_o;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
   logic [7:0]  ovr_cnt;
   logic [55:0] got;

   gpio_hex_display dut (
      .clk(clk), .rst(rst), .gpio_o(gpio_o), .we_gpio(we_gpio), .blank_lz(blank_lz),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
      .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
      .busy(busy), .upd_done(upd_done), .ovr_cnt(ovr_cnt)
   );

   assign got = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0, checks = 0, pulses = 0;

   typedef struct {int e; logic [55:0] hex;} ent_t;
   ent_t sb[$];

   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   bit m_active, m_pv, m_lz, m_plz;
   int m_commit, m_ovr;
   logic [31:0] m_word, m_pend;

   task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] x);
      checks++;
      if (g !== x) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, g, x);
      end
   endtask

   function automatic logic [55:0] disp(input logic [31:0] w, input logic lz);
      logic [55:0] r;
      logic [3:0]  n;
      for (int i = 0; i < 8; i++) begin
         n = w[4*i +: 4];
         r[7*i +: 7] = (lz && i != 0 && (w >> (4*i)) == 0) ? 7'b1111111 : seg_tab[n];
      end
      return r;
   endfunction

   function automatic logic [55:0] all_seg(input logic [6:0] s);
      return {8{s}};
   endfunction

   task automatic m_reset();
      m_active = 0; m_pv = 0; m_ovr = 0;
      sb.delete();
   endtask

   task automatic m_start(input int e, input logic [31:0] w, input logic l);
      m_active = 1; m_word = w; m_lz = l; m_commit = e + 9;
   endtask

   // e is the clock edge at which these inputs are sampled
   task automatic m_step(input int e, input logic w, input logic [31:0] d, input logic l);
      if (m_active && e == m_commit) begin
         ent_t en;
         en.e = e; en.hex = disp(m_word, m_lz);
         if (w) begin
            if (m_pv) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
            m_pv = 0;
            m_start(e, d, l);
         end else if (m_pv) begin
            m_pv = 0;
            m_start(e, m_pend, m_plz);
         end else m_active = 0;
         sb.push_back(en);
      end else if (m_active) begin
         if (w) begin
            if (m_pv) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
            m_pend = d; m_plz = l; m_pv = 1;
         end
      end else if (w) m_start(e, d, l);
   endtask

   task automatic step(input logic w, input logic [31:0] d, input logic l);
      @(negedge clk);
      chk("busy", 64'(busy), 64'(m_active | m_pv));
      chk("ovr_cnt", 64'(ovr_cnt), 64'(m_ovr));
      we_gpio = w; gpio_o = d; blank_lz = l;
      m_step(cyc + 1, w, d, l);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 32'h0, 1'b0);
   endtask

   always @(posedge clk) begin
      #1;
      if (!rst && upd_done) begin
         pulses++;
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL upd_unexpected: got upd_done=1 at cycle %0d expected no commit", cyc);
         end else begin
            ent_t en;
            en = sb.pop_front();
            chk("commit_cycle", 64'(cyc), 64'(en.e));
            chk("commit_hex", 64'(got), 64'(en.hex));
         end
      end
   end

   initial begin
      int p0;
      logic [31:0] w;
      rst = 1'b1; we_gpio = 1'b0; gpio_o = '0; blank_lz = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_hex", 64'(got), 64'(all_seg(7'b1000000)));
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_upd", 64'(upd_done), 64'd0);
      chk("rst_ovr", 64'(ovr_cnt), 64'd0);
      rst = 1'b0;

      step(1'b1, 32'h12345678, 1'b0);
      repeat (9) begin
         idle(1);
         chk("pre_commit_hex", 64'(got), 64'(all_seg(7'b1000000)));
      end
      idle(1);
      chk("t1_hex7", 64'(hex7), 64'(7'b1111001));
      chk("t1_hex6", 64'(hex6), 64'(7'b0100100));
      chk("t1_hex1", 64'(hex1), 64'(7'b1111000));
      chk("t1_hex0", 64'(hex0), 64'(7'b0000000));
      chk("t1_upd", 64'(upd_done), 64'd1);
      idle(1);
      chk("t1_upd_fall", 64'(upd_done), 64'd0);

      step(1'b1, 32'h000000A0, 1'b1);
      idle(11);
      chk("lz_hex7_2", 64'(got[55:14]), 64'(42'h3ffffffffff));
      chk("lz_hex1", 64'(hex1), 64'(7'b0001000));
      chk("lz_hex0", 64'(hex0), 64'(7'b1000000));
      step(1'b1, 32'h0, 1'b1);
      idle(11);
      chk("lz_zero", 64'(got), 64'({{7{7'b1111111}}, 7'b1000000}));

      step(1'b1, 32'hDEADBEEF, 1'b0);
      idle(1);
      step(1'b1, 32'h11111111, 1'b0);
      idle(8);
      chk("dead_hex7", 64'(hex7), 64'(7'b0100001));
      chk("dead_busy", 64'(busy), 64'd1);
      idle(12);
      chk("ones_hex", 64'(got), 64'(all_seg(7'b1111001)));
      chk("ones_ovr", 64'(ovr_cnt), 64'd0);

      p0 = pulses;
      step(1'b1, 32'hAAAA0001, 1'b0);
      idle(1);
      step(1'b1, 32'h0BBBBBBB, 1'b0);
      idle(1);
      step(1'b1, 32'hC0C0C0C0, 1'b0);
      idle(20);
      chk("abc_ovr", 64'(ovr_cnt), 64'd1);
      chk("abc_pulses", 64'(pulses - p0), 64'd2);
      chk("abc_hex", 64'(got), 64'(disp(32'hC0C0C0C0, 1'b0)));

      step(1'b1, 32'h5A5A5A5A, 1'b1);
      idle(4);
      @(negedge clk);
      rst = 1'b1;
      #1;
      m_reset();
      chk("midrst_hex", 64'(got), 64'(all_seg(7'b1000000)));
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_ovr", 64'(ovr_cnt), 64'd0);
      chk("midrst_upd", 64'(upd_done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      p0 = pulses;
      step(1'b1, 32'hFFFFFFFF, 1'b0);
      idle(11);
      chk("ff_hex", 64'(got), 64'(all_seg(7'b0001110)));
      chk("ff_pulses", 64'(pulses - p0), 64'd1);

      repeat (300) begin
         w = $urandom >> (4 * $urandom_range(0, 8));
         if ($urandom_range(0, 9) < 3) step(1'b1, w, 1'($urandom_range(0, 1)));
         else idle(1);
      end
      idle(12);

      repeat (400) step(1'b1, $urandom, 1'($urandom_range(0, 1)));
      idle(12);
      chk("sat_ovr", 64'(ovr_cnt), 64'hff);
      idle(5);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
